key_expand_seq: RTL and testbench
=================================

// Module: key_expand_seq
// PURPOSE
//  Iterative AES-128 key-schedule sequencer; drives the round-key path ahead of the cipher rounds.
//  Loads a 128-bit cipher key, computes round keys 1..10 at one per clock, and stores all 11.
//  Presents them as a packed 1408-bit expanded-key bus plus an indexed, registered read port.
// PARAMETERS
//  NR        10   number of rounds computed; round keys 0..NR stored (fixed 10 for AES-128)
//  IDX_W     4    width of round-key read index
// PORTS
//  clk          in   1     single clock, all state updates on posedge
//  rst          in   1     asynchronous, active-high reset
//  start        in   1     1-cycle request: latch key_in and begin expansion
//  key_in       in   128   cipher key; byte k at [8k+7:8k], word i at [32i+31:32i]
//  busy         out  1     high while rounds 1..NR are being computed
//  done         out  1     1-cycle pulse on the cycle the last round key is written
//  key_valid    out  1     high when the stored schedule is complete and matches the last start
//  expanded_key out  1408  {rk[10],...,rk[1],rk[0]}; rk[0] at [127:0]
//  rk_rd_idx    in   IDX_W round-key index to read
//  rk_rd_data   out  128   rk[rk_rd_idx], registered
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, key_valid=0, rk_rd_data=0, all stored round keys=0,
//    round counter=0. Reset asserted mid-expansion aborts immediately; no partial result is valid.
//  - FSM IDLE -> EXPAND on start. EXPAND -> DONE when counter==NR is written.
//    DONE -> EXPAND on start (re-key). DONE holds otherwise.
//  - On accepted start: rk[0]<=key_in, counter<=1, key_valid<=0, busy<=1 on the next cycle.
//  - In EXPAND, each cycle computes rk[c] from rk[c-1] and counter c:
//    t = rk[c-1][127:96]; RotWord in this byte order is {t[7:0],t[31:8]}.
//    SubWord applies the AES S-box to each byte. Then XOR Rcon(c) into byte [7:0].
//    Rcon: 1->01, 2->02, 3->04, 4->08, 5->10, 6->20, 7->40, 8->80, 9->1B, 10->36.
//    w4=t'^w0, w5=w4^w1, w6=w5^w2, w7=w6^w3, where w0..w3 are the words of rk[c-1].
//    rk[c]={w7,w6,w5,w4}; counter<=c+1.
//  - Latency: start at cycle 0; rk[1] is written at edge 2 and rk[10] at edge 11.
//    done pulses for 1 cycle with that final write. key_valid=1 and busy=0 from the next cycle.
//  - start while busy=1 is ignored; no restart, no queueing. start and rst together: rst wins.
//  - expanded_key reflects the stored registers at all times. Consumers sample it only when
//    key_valid=1. Slots not yet rewritten during a re-key hold stale data.
//  - Read port: rk_rd_data <= (rk_rd_idx<=NR) ? rk[rk_rd_idx] : 128'h0; 1-cycle latency.
//    Reads are legal in any state and return current register contents.
//  - Counter is 4 bits; it never exceeds NR and does not wrap. Unused counter values are
//    unreachable; if decoded, they force a return to IDLE.
// TESTING
//  1. Key 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, start -> rk[1]=128'h05766c2a_3939a323_b12c5488_17fefaa0;
//     rk[10]=128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0; done 11 cycles after start.
//  2. Key all-zero -> rk[1]=128'h63636362_63636362_63636362_63636362; key_valid=1 after done.
//  3. start pulsed again at cycle 5 of expansion -> ignored; results identical to scenario 1.
//  4. rst asserted at cycle 6 -> busy/key_valid/rk_rd_data=0 immediately; rk regs=0; a new start completes normally.
//  5. Read port: idx 0..10 -> matches expanded_key slices one cycle later; idx 11..15 -> 0.
//  6. Re-key from DONE with the zero key after scenario 1 -> key_valid drops the cycle after start;
//     final schedule equals scenario 2.

Source files
------------

// File: rtl/key_expand_seq.sv
// Iterative AES-128 key-schedule sequencer: latches a cipher key, derives round keys 1..NR
// at one per clock, and exposes the stored schedule as a packed bus and a registered read port.
module key_expand_seq #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [127:0]            key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    key_valid,
  output logic [128*(NR+1)-1:0]   expanded_key,
  input  logic [IDX_W-1:0]        rk_rd_idx,
  output logic [127:0]            rk_rd_data
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] NR_C = 4'(NR);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] c);
    case (c)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   rk_q [0:NR];
  logic [127:0]   rk_d [0:NR];
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           key_valid_q, key_valid_d;
  logic [127:0]   rd_data_q, rd_data_d;

  logic [127:0]   prev_key;
  logic [31:0]    rot_word, sub_word;
  logic [31:0]    w4, w5, w6, w7;

  // Round-key function applied to the slot just below the counter.
  always_comb begin
    prev_key = 128'h0;
    for (int c = 1; c <= NR; c++) begin
      if (cnt_q == 4'(c)) prev_key = rk_q[c-1];
    end
    rot_word = {prev_key[103:96], prev_key[127:104]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),  sbox(rot_word[7:0]) ^ rcon(cnt_q)};
    w4 = sub_word ^ prev_key[31:0];
    w5 = w4 ^ prev_key[63:32];
    w6 = w5 ^ prev_key[95:64];
    w7 = w6 ^ prev_key[127:96];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rk_d        = rk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    rd_data_d   = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_rd_idx == IDX_W'(i)) rd_data_d = rk_q[i];
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rk_d[0]     = key_in;
          cnt_d       = 4'd1;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        if (cnt_q == 4'd0 || cnt_q > NR_C) begin
          // Unreachable counter value: abandon the schedule.
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end else begin
          for (int c = 1; c <= NR; c++) begin
            if (cnt_q == 4'(c)) rk_d[c] = {w7, w6, w5, w4};
          end
          if (cnt_q == NR_C) begin
            done_d      = 1'b1;
            key_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_data_q   <= 128'h0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= 128'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_pack
    assign expanded_key[128*g +: 128] = rk_q[g];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign key_valid  = key_valid_q;
  assign rk_rd_data = rd_data_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: random and known keys checked against a byte-level AES-128
// key-expansion model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_key_expand_seq;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [127:0]    key_in = 128'h0;
  logic            busy, done, key_valid;
  logic [1407:0]   expanded_key;
  logic [3:0]      rk_rd_idx = 4'd0;
  logic [127:0]    rk_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] mrk [0:10];

  localparam logic [127:0] KEY1    = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] K1_RK1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] K1_RK10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
  localparam logic [127:0] K0_RK1  = 128'h63636362_63636362_63636362_63636362;

  key_expand_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .key_valid(key_valid),
    .expanded_key(expanded_key), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [7:0] w [0:43][0:3];
    logic [7:0] t [0:3];
    logic [7:0] tmp0;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        tmp0 = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp0];
        rc = xtime(rc);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int r = 0; r <= 10; r++)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++) mrk[r][8*(4*k+j) +: 8] = w[4*r+k][j];
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulses start for one cycle; returns the cycle number in which start was presented.
  task automatic pulse_start(input logic [127:0] key, output int c0);
    c0 = cyc;
    key_in = key;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Steps until done is seen (bounded); returns its cycle number, or -1 on timeout.
  task automatic wait_done(output int c_done);
    c_done = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        c_done = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic check_schedule(input string name);
    for (int r = 0; r <= 10; r++) begin
      n_tests++;
      if (expanded_key[128*r +: 128] !== mrk[r]) begin
        n_fail++;
        $display("FAIL %s rk[%0d]: got %h expected %h", name, r, expanded_key[128*r +: 128], mrk[r]);
      end
    end
  endtask

  task automatic run_key(input string name, input logic [127:0] key);
    int c0, cd;
    model_expand(key);
    pulse_start(key, c0);
    wait_done(cd);
    n_tests++;
    if (cd !== c0 + 11) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, cd - c0, 11);
    end
    n_tests++;
    if ({key_valid, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s valid_busy_at_done: got %b expected 10", name, {key_valid, busy});
    end
    step();
    n_tests++;
    if ({done, key_valid, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s after_done: got %b expected 010", name, {done, key_valid, busy});
    end
    check_schedule(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step();
    step();
    n_tests++;
    if ({busy, done, key_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, key_valid});
    end
    n_tests++;
    if (rk_rd_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h expected 0", rk_rd_data);
    end
    n_tests++;
    if (expanded_key !== 1408'h0) begin
      n_fail++;
      $display("FAIL reset_expanded_key: nonzero, low slice %h", expanded_key[127:0]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_known_vector();
    run_key("known_vector", KEY1);
    n_tests++;
    if (expanded_key[255:128] !== K1_RK1) begin
      n_fail++;
      $display("FAIL known_rk1: got %h expected %h", expanded_key[255:128], K1_RK1);
    end
    n_tests++;
    if (expanded_key[1407:1280] !== K1_RK10) begin
      n_fail++;
      $display("FAIL known_rk10: got %h expected %h", expanded_key[1407:1280], K1_RK10);
    end
  endtask

  task automatic test_rekey_zero();
    int c0, cd;
    model_expand(128'h0);
    pulse_start(128'h0, c0);
    n_tests++;
    if ({key_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL rekey_valid_drop: got %b expected 01", {key_valid, busy});
    end
    wait_done(cd);
    n_tests++;
    if (cd !== c0 + 11) begin
      n_fail++;
      $display("FAIL rekey_latency: got %0d expected 11", cd - c0);
    end
    step();
    n_tests++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rekey_key_valid: got %b expected 1", key_valid);
    end
    check_schedule("rekey_zero");
    n_tests++;
    if (expanded_key[255:128] !== K0_RK1) begin
      n_fail++;
      $display("FAIL zero_rk1: got %h expected %h", expanded_key[255:128], K0_RK1);
    end
  endtask

  task automatic test_start_while_busy();
    int c0, cd;
    model_expand(KEY1);
    pulse_start(KEY1, c0);
    while (cyc < c0 + 4) step();
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done(cd);
    n_tests++;
    if (cd !== c0 + 11) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d expected 11", cd - c0);
    end
    step();
    check_schedule("start_while_busy");
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(k, c0);
    while (cyc < c0 + 6) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, key_valid, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_flags: got %b expected 000", {busy, key_valid, done});
    end
    n_tests++;
    if (rk_rd_data !== 128'h0) begin
      n_fail++;
      $display("FAIL midrst_rd_data: got %h expected 0", rk_rd_data);
    end
    n_tests++;
    if (expanded_key !== 1408'h0) begin
      n_fail++;
      $display("FAIL midrst_regs: nonzero, rk0 %h", expanded_key[127:0]);
    end
    step();
    rst = 1'b0;
    step();
    step();
    n_tests++;
    if ({busy, key_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_idle: got %b expected 00", {busy, key_valid});
    end
    run_key("after_midrst", {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_read_port();
    logic [127:0] exp_rd;
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      step();
      exp_rd = (i <= 10) ? mrk[i] : 128'h0;
      n_tests++;
      if (rk_rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL read_idx%0d: got %h expected %h", i, rk_rd_data, exp_rd);
      end
    end
    for (int i = 0; i < 8; i++) begin
      rk_rd_idx = 4'($urandom_range(0, 15));
      step();
      exp_rd = (rk_rd_idx <= 4'd10) ? mrk[rk_rd_idx] : 128'h0;
      n_tests++;
      if (rk_rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL read_rand idx%0d: got %h expected %h", rk_rd_idx, rk_rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 4; n++)
      run_key("random_key", {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vector();
    test_read_port();
    test_rekey_zero();
    test_start_while_busy();
    test_reset_mid();
    test_read_port();
    test_random_keys();
    test_read_port();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
